// File: rtl/adc_deserializer.sv
// Word-framed multi-channel serial-to-parallel capture with frame resync,
// a valid/ready holding register and sticky overflow/drop accounting.
module adc_deserializer #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned WORD_W    = 32,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                       adc_clk_i,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          adc_data_i,
    input  logic                       adc_en_i,
    input  logic                       frame_sync_i,
    output logic [NUM_CH*WORD_W-1:0]   word_o,
    output logic                       word_valid_o,
    input  logic                       word_ready_i,
    output logic                       overflow_o,
    input  logic                       overflow_clr_i,
    output logic [7:0]                 drop_cnt_o
);

    localparam int unsigned CNT_W  = $clog2(WORD_W);
    localparam int unsigned DATA_W = NUM_CH * WORD_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_e;

    hold_state_e                       state_q, state_d;
    logic [NUM_CH-1:0][WORD_W-1:0]     sr_q, sr_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [DATA_W-1:0]                 word_q, word_d;
    logic                              overflow_q, overflow_d;
    logic [7:0]                        drop_cnt_q, drop_cnt_d;
    logic                              complete;
    logic                              handshake;
    logic                              drop;

    // Shift registers and bit counter; frame sync outranks word completion.
    always_comb begin
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        complete = 1'b0;
        if (adc_en_i) begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                if (MSB_FIRST) begin
                    sr_d[k] = {sr_q[k][WORD_W-2:0], adc_data_i[k]};
                end else begin
                    sr_d[k] = {adc_data_i[k], sr_q[k][WORD_W-1:1]};
                end
            end
        end
        if (frame_sync_i) begin
            cnt_d = adc_en_i ? CNT_W'(1) : '0;
        end else if (adc_en_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d    = '0;
                complete = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Holding register FSM plus overflow accounting.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        drop       = 1'b0;
        handshake  = (state_q == FULL) && word_ready_i;
        case (state_q)
            EMPTY: begin
                if (complete) begin
                    state_d = FULL;
                    word_d  = sr_d;
                end
            end
            FULL: begin
                if (complete && handshake) begin
                    word_d = sr_d;
                end else if (complete) begin
                    drop = 1'b1;
                end else if (handshake) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
            if (overflow_clr_i) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (overflow_clr_i) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge adc_clk_i) begin
        if (reset) begin
            state_q    <= EMPTY;
            sr_q       <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = (state_q == FULL);
    assign overflow_o   = overflow_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_adc_deserializer.sv
// Randomised scoreboard bench: LSB-first and MSB-first instances share stimulus
// and are checked against a bit-history reference model.
module tb_adc_deserializer;

    localparam int unsigned NCH = 4;
    localparam int unsigned WW  = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NCH-1:0]  data = '0;
    logic            en = 1'b0;
    logic            sync = 1'b0;
    logic            rdy = 1'b0;
    logic            clr = 1'b0;
    logic [31:0]     word_l, word_m;
    logic            valid_l, valid_m, ovf_l, ovf_m;
    logic [7:0]      drop_l, drop_m;

    int checks   = 0;
    int failures = 0;
    bit mon_on   = 1'b0;

    // Reference model state
    logic [NCH-1:0]  hist[$];
    bit              m_valid;
    bit              m_ovf;
    int              m_drop;
    logic [31:0]     m_last_l, m_last_m;
    logic [31:0]     q_l[$];
    logic [31:0]     q_m[$];

    always #5 clk = ~clk;

    adc_deserializer #(.NUM_CH(NCH), .WORD_W(WW), .MSB_FIRST(1'b0)) u_dut_l (
        .adc_clk_i(clk), .reset(rst), .adc_data_i(data), .adc_en_i(en),
        .frame_sync_i(sync), .word_o(word_l), .word_valid_o(valid_l),
        .word_ready_i(rdy), .overflow_o(ovf_l), .overflow_clr_i(clr),
        .drop_cnt_o(drop_l)
    );

    adc_deserializer #(.NUM_CH(NCH), .WORD_W(WW), .MSB_FIRST(1'b1)) u_dut_m (
        .adc_clk_i(clk), .reset(rst), .adc_data_i(data), .adc_en_i(en),
        .frame_sync_i(sync), .word_o(word_m), .word_valid_o(valid_m),
        .word_ready_i(rdy), .overflow_o(ovf_m), .overflow_clr_i(clr),
        .drop_cnt_o(drop_m)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advance for one rising edge, given the inputs applied on it.
    task automatic model_step(input logic e, input logic [NCH-1:0] d, input logic s,
                              input logic r, input logic c, input logic rs);
        bit          hs, done, dropped;
        logic [31:0] wl, wm;
        if (rs) begin
            hist.delete();
            m_valid = 0; m_ovf = 0; m_drop = 0;
            m_last_l = '0; m_last_m = '0;
            q_l.delete(); q_m.delete();
            return;
        end
        hs = m_valid && r;
        done = 0; dropped = 0;
        wl = '0; wm = '0;
        if (s) begin
            hist.delete();
            if (e) hist.push_back(d);
        end else if (e) begin
            hist.push_back(d);
            if (hist.size() == WW) begin
                done = 1;
                for (int i = 0; i < int'(WW); i++)
                    for (int k = 0; k < int'(NCH); k++) begin
                        wl[k*WW + i]          = hist[i][k];
                        wm[k*WW + (WW-1) - i] = hist[i][k];
                    end
                hist.delete();
            end
        end
        if (done) begin
            if (!m_valid || hs) begin
                m_valid = 1; m_last_l = wl; m_last_m = wm;
                q_l.push_back(wl); q_m.push_back(wm);
            end else begin
                dropped = 1;
                m_ovf = 1;
                m_drop = c ? 1 : (m_drop == 255 ? 255 : m_drop + 1);
            end
        end else if (hs) begin
            m_valid = 0;
        end
        if (!dropped && c) begin
            m_ovf = 0; m_drop = 0;
        end
    endtask

    task automatic step(input logic e, input logic [NCH-1:0] d, input logic s,
                        input logic r, input logic c, input logic rs);
        en = e; data = d; sync = s; rdy = r; clr = c; rst = rs;
        @(posedge clk);
        model_step(e, d, s, r, c, rs);
        #1;
    endtask

    // Scoreboard monitor: compare status every cycle, pop words on handshake.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("valid_l", 32'(valid_l), 32'(m_valid));
            chk("valid_m", 32'(valid_m), 32'(m_valid));
            chk("ovf_l", 32'(ovf_l), 32'(m_ovf));
            chk("ovf_m", 32'(ovf_m), 32'(m_ovf));
            chk("drop_l", 32'(drop_l), 32'(m_drop));
            chk("drop_m", 32'(drop_m), 32'(m_drop));
            if (valid_l) begin
                if (q_l.size() == 0 || q_m.size() == 0) begin
                    chk("word_noexp", 32'(q_l.size()), 32'd1);
                end else begin
                    chk("word_l", word_l, q_l[0]);
                    chk("word_m", word_m, q_m[0]);
                    if (rdy) begin
                        void'(q_l.pop_front());
                        void'(q_m.pop_front());
                    end
                end
            end else begin
                chk("word_l_idle", word_l, m_last_l);
                chk("word_m_idle", word_m, m_last_m);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat[NCH];
        logic [7:0] v5a;
        pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'hFF; pat[3] = 8'h00;
        v5a = 8'h5A;

        step(0, '0, 0, 0, 0, 1);
        step(0, '0, 0, 0, 0, 1);
        mon_on = 1'b1;
        chk("rst_word", word_l, 32'h0);
        chk("rst_valid", 32'(valid_l), 32'h0);

        // ch0 stream 1,0,0,... with sync on the first bit
        for (int i = 0; i < int'(WW); i++)
            step(1, (i == 0) ? 4'b0001 : 4'b0000, (i == 0), 1, 0, 0);
        chk("lsb_one", word_l, 32'h0000_0001);
        chk("msb_one", word_m, 32'h0000_0080);
        chk("one_valid", 32'(valid_l), 32'h1);
        step(0, '0, 0, 1, 0, 0);

        // alternating enable, pattern held with ready low
        for (int i = 0; i < 2*int'(WW); i++) begin
            if (i % 2 == 0)
                step(1, {pat[3][i/2], pat[2][i/2], pat[1][i/2], pat[0][i/2]}, (i == 0), 0, 0, 0);
            else
                step(0, 4'($urandom), 0, 0, 0, 0);
        end
        chk("alt_word", word_l, 32'h00FF_3CA5);
        step(0, '0, 0, 1, 0, 0);

        // three words with ready low: two drops
        for (int i = 0; i < 3*int'(WW); i++)
            step(1, 4'($urandom), (i == 0), 0, 0, 0);
        chk("drop2_cnt", 32'(drop_l), 32'd2);
        chk("drop2_ovf", 32'(ovf_l), 32'd1);
        step(0, '0, 0, 1, 0, 0);
        chk("drain_valid", 32'(valid_l), 32'd0);
        step(0, '0, 0, 0, 1, 0);
        chk("clr_cnt", 32'(drop_l), 32'd0);
        chk("clr_ovf", 32'(ovf_l), 32'd0);

        // saturation, then clear coincident with a drop
        for (int i = 0; i < 300*int'(WW); i++)
            step(1, 4'($urandom), 0, 0, 0, 0);
        chk("sat_cnt", 32'(drop_l), 32'd255);
        step(1, 4'($urandom), 1, 0, 0, 0);
        for (int i = 0; i < int'(WW) - 2; i++)
            step(1, 4'($urandom), 0, 0, 0, 0);
        step(1, 4'($urandom), 0, 0, 1, 0);
        chk("clrdrop_cnt", 32'(drop_l), 32'd1);
        chk("clrdrop_ovf", 32'(ovf_l), 32'd1);
        step(0, '0, 0, 1, 1, 0);

        // resync after 5 bits, then 0x5A on ch0
        for (int i = 0; i < 5; i++)
            step(1, 4'($urandom), 0, 1, 0, 0);
        for (int i = 0; i < int'(WW); i++)
            step(1, {3'($urandom), v5a[i]}, (i == 0), 0, 0, 0);
        chk("resync_word", 32'(word_l[7:0]), 32'h5A);
        step(0, '0, 0, 1, 0, 0);
        // sync landing on the last bit suppresses completion
        for (int i = 0; i < int'(WW); i++)
            step(1, 4'($urandom), (i == 0) || (i == int'(WW) - 1), 1, 0, 0);
        chk("sync_last_valid", 32'(valid_l), 32'd0);

        // reset while full and mid-word
        for (int i = 0; i < int'(WW) + 3; i++)
            step(1, 4'($urandom), (i == 0), 0, 0, 0);
        step(1, 4'($urandom), 0, 0, 0, 1);
        chk("rst2_word", word_l, 32'h0);
        chk("rst2_valid", 32'(valid_l), 32'd0);
        chk("rst2_ovf", 32'(ovf_l), 32'd0);
        for (int i = 0; i < int'(WW) - 1; i++)
            step(1, 4'($urandom), 0, 0, 0, 0);
        chk("fresh_pre", 32'(valid_l), 32'd0);
        step(1, 4'($urandom), 0, 0, 0, 0);
        chk("fresh_done", 32'(valid_l), 32'd1);

        // randomised traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 7, 4'($urandom), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 299) == 0);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_deserializer.md
# adc_deserializer

Parametrised multi-channel serial-to-parallel capture block for the ADC front end. It replaces the fixed 4-channel, 32-bit, free-running capture buffer with a word-framed deserializer. That design has configurable channel count, word width and bit order, a bit-enable qualifier, frame resynchronisation, and a valid/ready holding register with overflow accounting. It sits between the ADC pins (via the DIO pad register) and the blockram/Wishbone writer in the top module.

## Interface
- NUM_CH, 4: number of serial ADC channels; 1..8.
- WORD_W, 32: bits per captured word; 2..32.
- MSB_FIRST, 0: 0 = first serial bit lands in word bit 0 (LSB-first); 1 = first serial bit lands in word bit WORD_W-1.

- adc_clk_i  in  1  sole clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- adc_data_i  in  NUM_CH  serial data; bit k = channel k.
- adc_en_i  in  1  bit strobe; data is sampled only on edges where adc_en_i=1.
- frame_sync_i  in  1  word-boundary marker; realigns the bit counter.
- word_o  out  NUM_CH*WORD_W  held word; channel k at [k*WORD_W +: WORD_W].
- word_valid_o  out  1  word_o holds an unconsumed word.
- word_ready_i  in  1  consumer accepts word_o when word_valid_o=1.
- overflow_o  out  1  sticky; at least one completed word was dropped.
- overflow_clr_i  in  1  clears overflow_o and drop_cnt_o.
- drop_cnt_o  out  8  count of dropped words; saturates at 255.

## Operation
- Each channel has a WORD_W-bit shift register. When adc_en_i=1, it shifts in adc_data_i[k]:
  - LSB-first: {bit, sr[WORD_W-1:1]}.
  - MSB-first: {sr[WORD_W-2:0], bit}.
- Bit counter: width clog2(WORD_W), range 0..WORD_W-1. It advances only on adc_en_i=1 and wraps from WORD_W-1 to 0.
- Word completion happens on an enabled edge with counter=WORD_W-1 and frame_sync_i=0. The assembled word includes the bit sampled on that edge. For every channel, the word is the shift-register next-state value.
- frame_sync_i=1 with adc_en_i=1: the current bit becomes bit 0 of a new word and the counter loads 1. The partial word is discarded and never emitted. The shift register still shifts.
- frame_sync_i=1 with adc_en_i=0: the counter loads 0 and nothing shifts.
- Frame sync takes priority over completion. A sync on the WORD_W-1 edge produces no word.
- Holding register has two states, EMPTY (word_valid_o=0) and FULL (word_valid_o=1):
  - EMPTY + completion → FULL, word_o loaded.
  - FULL + word_valid_o&word_ready_i, no completion → EMPTY. word_o retains its last value.
  - FULL + handshake + completion on the same edge → stays FULL with the new word (no drop).
  - FULL + no handshake + completion → word dropped. word_o unchanged, overflow_o←1, drop_cnt_o increments (saturating).
- word_ready_i is ignored while EMPTY.
- overflow_clr_i=1 clears overflow_o and drop_cnt_o to 0. If a drop occurs on the same edge, the drop wins: overflow_o=1, drop_cnt_o=1.
- Reset: shift registers, counter and word_o go to 0; word_valid_o=0, overflow_o=0, drop_cnt_o=0. Reset mid-word discards the partial word. Reset while FULL discards the held word. The first post-reset enabled bit is bit 0.

## Timing
- Completion latency: word_valid_o and the new word_o appear 1 cycle after the edge sampling the last bit, i.e. registered on that edge.
- Back-to-back words with adc_en_i held high: one completion every WORD_W cycles. A consumer with word_ready_i tied high never causes a drop.
- Handshake is combinationally independent. word_valid_o does not depend on word_ready_i in the same cycle.
- overflow_o and drop_cnt_o update on the drop edge. They are visible the next cycle.
- Sustained ready: with word_ready_i=1 in the cycle after completion, word_valid_o is high for exactly 1 cycle.

## Test plan
- Default params, adc_en_i=1, frame_sync_i pulsed with the first bit, ch0 serial 1,0,0…0 (32 bits), word_ready_i=1 → word_o[31:0]=0x00000001 and word_valid_o=1 one cycle after bit 32. With MSB_FIRST=1 the same stream → 0x80000000.
- NUM_CH=4, WORD_W=8, channels stream 0xA5, 0x3C, 0xFF, 0x00 LSB-first with adc_en_i alternating 1/0 → word_o=0x00FF3CA5 after 16 cycles. Disabled cycles change nothing.
- word_ready_i=0 across three completed words → first word held, overflow_o=1, drop_cnt_o=2. Raise ready → one handshake, valid drops. Pulse overflow_clr_i → overflow_o=0, drop_cnt_o=0.
- Hold ready=0 for 300 words → drop_cnt_o saturates at 255. overflow_clr_i coincident with a drop → drop_cnt_o=1, overflow_o=1.
- WORD_W=8: frame_sync_i after 5 bits, then 8 bits of 0x5A → exactly one word 0x5A, no partial word emitted. Sync on the 8th bit → no completion.
- Assert reset mid-word with word_valid_o=1 → next cycle all outputs 0. A fresh 32-bit stream then completes after exactly 32 enabled bits.
